// File: rtl/ow_slave_responder.sv
// 1-wire slave responder: detects master bus resets and answers with a
// presence pulse, serves read slots from an 8-bit transmit buffer (MSB
// first) and assembles write slots into received bytes. The bus is open
// drain: the slave only ever pulls it low.
module ow_slave_responder #(
    parameter int RESET_MIN  = 64,
    parameter int PRES_DELAY = 8,
    parameter int PRES_LEN   = 32,
    parameter int HOLD_LEN   = 40,
    parameter int SAMPLE_AT  = 20
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        bus,
    input  logic       tx_mode,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       bus_reset_det,
    output logic       underrun,
    output logic       drive_low
);

    // One counter width wide enough for every cycle count the block keeps.
    localparam int CW = $clog2(RESET_MIN + PRES_DELAY + PRES_LEN + HOLD_LEN + SAMPLE_AT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOT,
        ST_RST_LOW,
        ST_PRES_WAIT,
        ST_PRES_DRIVE
    } state_t;

    state_t          state_r;
    logic            sync1_r;
    logic            sync2_r;
    logic            sync3_r;
    logic            drv_d1_r;
    logic            drv_d2_r;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   low_cnt_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      rx_shift_r;
    logic [7:0]      rx_data_r;
    logic [7:0]      tx_buf_r;
    logic            slot_tx_r;
    logic            slot_under_r;
    logic            tx_ready_r;
    logic            rx_valid_r;
    logic            det_r;
    logic            underrun_r;
    logic            drive_low_r;

    logic            bus_s;
    logic            fall_s;
    logic            undriven_low_s;

    // Open-drain output: pull low or float, never drive high.
    assign bus = drive_low_r ? 1'b0 : 1'bz;

    // drv_d2_r lines up our own drive with what the synchroniser shows, so
    // the slave's own low never looks like a master edge or a reset pulse.
    assign bus_s          = sync2_r;
    assign fall_s         = sync3_r & ~sync2_r & ~drive_low_r & ~drv_d2_r;
    assign undriven_low_s = ~bus_s & ~drv_d2_r;

    assign tx_ready      = tx_ready_r;
    assign rx_data       = rx_data_r;
    assign rx_valid      = rx_valid_r;
    assign bus_reset_det = det_r;
    assign underrun      = underrun_r;
    assign drive_low     = drive_low_r;

    // Bus synchroniser, previous-value flop and matching own-drive delay line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            sync3_r  <= 1'b1;
            drv_d1_r <= 1'b0;
            drv_d2_r <= 1'b0;
        end else begin
            sync1_r  <= bus;
            sync2_r  <= sync1_r;
            sync3_r  <= sync2_r;
            drv_d1_r <= drive_low_r;
            drv_d2_r <= drv_d1_r;
        end
    end

    // Slot/reset/presence state machine with registered outputs and the
    // transmit-buffer handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            low_cnt_r    <= '0;
            bit_cnt_r    <= 3'd0;
            rx_shift_r   <= 8'h00;
            rx_data_r    <= 8'h00;
            tx_buf_r     <= 8'h00;
            slot_tx_r    <= 1'b0;
            slot_under_r <= 1'b0;
            tx_ready_r   <= 1'b1;
            rx_valid_r   <= 1'b0;
            det_r        <= 1'b0;
            underrun_r   <= 1'b0;
            drive_low_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            det_r      <= 1'b0;
            underrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_r      <= ST_SLOT;
                        cnt_r        <= '0;
                        low_cnt_r    <= '0;
                        slot_tx_r    <= tx_mode;
                        slot_under_r <= 1'b0;
                        if (tx_mode) begin
                            if (tx_ready_r) begin
                                // Nothing to send: the line floats, master reads 1.
                                underrun_r   <= 1'b1;
                                slot_under_r <= 1'b1;
                            end else begin
                                drive_low_r <= ~tx_buf_r[3'd7 - bit_cnt_r];
                            end
                        end
                    end
                end
                ST_SLOT: begin
                    if (cnt_r != CW'(HOLD_LEN)) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                    if (drive_low_r && (cnt_r == CW'(HOLD_LEN - 1))) begin
                        drive_low_r <= 1'b0;
                    end
                    if (!slot_tx_r && (cnt_r == CW'(SAMPLE_AT))) begin
                        rx_shift_r <= {rx_shift_r[6:0], bus_s};
                    end
                    if (undriven_low_s) begin
                        if (low_cnt_r == CW'(RESET_MIN - 1)) begin
                            // Master reset pulse: abandon the byte in flight.
                            state_r     <= ST_RST_LOW;
                            bit_cnt_r   <= 3'd0;
                            rx_shift_r  <= 8'h00;
                            tx_buf_r    <= 8'h00;
                            tx_ready_r  <= 1'b1;
                            drive_low_r <= 1'b0;
                        end else begin
                            low_cnt_r <= low_cnt_r + CW'(1);
                        end
                    end else begin
                        low_cnt_r <= '0;
                        if (bus_s && !drive_low_r && (cnt_r >= CW'(HOLD_LEN))) begin
                            state_r <= ST_IDLE;
                            // An underrun slot carries no byte data, so the next
                            // loaded byte still starts at bit 7.
                            if (!(slot_tx_r && slot_under_r)) begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                                if (bit_cnt_r == 3'd7) begin
                                    if (slot_tx_r) begin
                                        tx_ready_r <= 1'b1;
                                    end else begin
                                        rx_data_r  <= rx_shift_r;
                                        rx_valid_r <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_RST_LOW: begin
                    if (bus_s) begin
                        det_r   <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= ST_PRES_WAIT;
                    end
                end
                ST_PRES_WAIT: begin
                    if (cnt_r == CW'(PRES_DELAY - 1)) begin
                        cnt_r       <= '0;
                        drive_low_r <= 1'b1;
                        state_r     <= ST_PRES_DRIVE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_PRES_DRIVE: begin
                    if (drive_low_r) begin
                        if (cnt_r == CW'(PRES_LEN - 1)) begin
                            drive_low_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CW'(1);
                        end
                    end else if (bus_s && !drv_d2_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    drive_low_r <= 1'b0;
                end
            endcase
            // A load is only taken while the buffer is empty; it wins over a
            // same-cycle wrap or abort that would mark the buffer empty again.
            if (tx_load && tx_ready_r) begin
                tx_buf_r   <= tx_data;
                tx_ready_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ow_slave_responder.sv
// Directed bench for ow_slave_responder: plays a 1-wire master on the bus
// and checks presence timing, read slots, write slots, aborts and reset.
module tb_ow_slave_responder;

    localparam int PRES_DELAY = 8;
    localparam int PRES_LEN   = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_mode;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       bus_reset_det;
    logic       underrun;
    logic       drive_low;
    logic       master_low;
    wire        bus;

    int total = 0;
    int bad   = 0;
    int und_cnt = 0;
    int rxv_cnt = 0;
    int det_cnt = 0;
    int drv_cnt = 0;

    pullup (bus);
    assign bus = master_low ? 1'b0 : 1'bz;

    ow_slave_responder dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .tx_mode       (tx_mode),
        .tx_data       (tx_data),
        .tx_load       (tx_load),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .bus_reset_det (bus_reset_det),
        .underrun      (underrun),
        .drive_low     (drive_low)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (underrun === 1'b1)      und_cnt <= und_cnt + 1;
        if (rx_valid === 1'b1)      rxv_cnt <= rxv_cnt + 1;
        if (bus_reset_det === 1'b1) det_cnt <= det_cnt + 1;
        if (drive_low === 1'b1)     drv_cnt <= drv_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
    endtask

    // One master slot: low for low_len cycles, sample at samp, period cycles long.
    task automatic mslot(input int low_len, input int samp, input int period, output logic rd);
        rd = 1'bx;
        master_low = 1'b1;
        for (int c = 1; c <= period; c++) begin
            tick();
            if (c == low_len) master_low = 1'b0;
            if (c == samp) rd = bus;
        end
    endtask

    // Master reset pulse of len cycles; measures the presence pulse that follows.
    task automatic bus_reset(input int len, output int dly, output int plen, output int blow);
        master_low = 1'b1;
        repeat (len) tick();
        master_low = 1'b0;
        dly = 0;
        plen = 0;
        blow = 0;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (drive_low === 1'b1) begin
                if (dly == 0) dly = n;
                plen++;
                if (bus === 1'b0) blow++;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (tx_ready !== 1'b1 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: tx_ready=%b rx_data=%h rx_valid=%b, required 1 00 0", tx_ready, rx_data, rx_valid);
        end
        total++;
        if (bus_reset_det !== 1'b0 || underrun !== 1'b0 || drive_low !== 1'b0 || bus !== 1'b1) begin
            bad++;
            $display("FAIL reset_bus: det=%b underrun=%b drive_low=%b bus=%b, required 0 0 0 1", bus_reset_det, underrun, drive_low, bus);
        end
    endtask

    task automatic test_bus_reset();
        int d0, dly, plen, blow;
        tx_mode = 1'b0;
        d0 = det_cnt;
        bus_reset(80, dly, plen, blow);
        total++;
        if (det_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL presence_det_count: got %0d, required 1", det_cnt - d0);
        end
        total++;
        if (dly < PRES_DELAY + 2 || dly > PRES_DELAY + 4) begin
            bad++;
            $display("FAIL presence_delay: got %0d cycles, required %0d..%0d", dly, PRES_DELAY + 2, PRES_DELAY + 4);
        end
        total++;
        if (plen !== PRES_LEN || blow !== PRES_LEN) begin
            bad++;
            $display("FAIL presence_len: drive=%0d bus_low=%0d, required %0d", plen, blow, PRES_LEN);
        end
        total++;
        if (drive_low !== 1'b0 || bus !== 1'b1) begin
            bad++;
            $display("FAIL presence_release: drive_low=%b bus=%b, required 0 1", drive_low, bus);
        end
    endtask

    task automatic test_transmit();
        logic rd;
        logic [7:0] got;
        int u0;
        u0 = und_cnt;
        tx_mode = 1'b1;
        load_byte(8'hA5);
        total++;
        if (tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL tx_ready_after_load: got %b, required 0", tx_ready);
        end
        load_byte(8'hFF);
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mslot(17, 31, 47, rd);
            got = {got[6:0], rd};
            if (i == 6) begin
                total++;
                if (tx_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL tx_ready_early: got %b after 7 slots, required 0", tx_ready);
                end
            end
        end
        total++;
        if (got !== 8'hA5) begin
            bad++;
            $display("FAIL tx_byte: master read %h, required a5", got);
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL tx_ready_wrap: got %b, required 1", tx_ready);
        end
        total++;
        if (und_cnt - u0 !== 0) begin
            bad++;
            $display("FAIL tx_no_underrun: got %0d pulses, required 0", und_cnt - u0);
        end
    endtask

    task automatic test_underrun();
        logic rd;
        int u0, v0, dly, plen, blow;
        tx_mode = 1'b1;
        u0 = und_cnt;
        v0 = drv_cnt;
        mslot(17, 31, 47, rd);
        total++;
        if (und_cnt - u0 !== 1) begin
            bad++;
            $display("FAIL underrun_count: got %0d, required 1", und_cnt - u0);
        end
        total++;
        if (rd !== 1'b1 || drv_cnt - v0 !== 0) begin
            bad++;
            $display("FAIL underrun_bus: read %b drive_cycles %0d, required 1 0", rd, drv_cnt - v0);
        end
        tx_mode = 1'b0;
        bus_reset(80, dly, plen, blow);
    endtask

    task automatic test_receive();
        int lens[8] = '{30, 5, 30, 30, 30, 5, 5, 5};
        logic rd;
        int r0;
        tx_mode = 1'b0;
        r0 = rxv_cnt;
        for (int i = 0; i < 8; i++) begin
            mslot(lens[i], 1000, 60, rd);
            if (i == 6) begin
                total++;
                if (rxv_cnt - r0 !== 0) begin
                    bad++;
                    $display("FAIL rx_valid_early: got %0d pulses after 7 slots, required 0", rxv_cnt - r0);
                end
            end
        end
        total++;
        if (rx_data !== 8'h47) begin
            bad++;
            $display("FAIL rx_byte: got %h, required 47", rx_data);
        end
        total++;
        if (rxv_cnt - r0 !== 1) begin
            bad++;
            $display("FAIL rx_valid_count: got %0d, required 1", rxv_cnt - r0);
        end
    endtask

    task automatic test_abort();
        logic rd;
        logic [2:0] bits;
        logic [7:0] got;
        int d0, u0, dly, plen, blow;
        tx_mode = 1'b1;
        load_byte(8'h3C);
        bits = 3'b000;
        for (int i = 0; i < 3; i++) begin
            mslot(17, 31, 47, rd);
            bits = {bits[1:0], rd};
        end
        total++;
        if (bits !== 3'b001) begin
            bad++;
            $display("FAIL abort_prefix: got %b, required 001", bits);
        end
        d0 = det_cnt;
        bus_reset(70, dly, plen, blow);
        total++;
        if (det_cnt - d0 !== 1 || tx_ready !== 1'b1 || plen !== PRES_LEN) begin
            bad++;
            $display("FAIL abort_state: det=%0d tx_ready=%b presence=%0d, required 1 1 %0d", det_cnt - d0, tx_ready, plen, PRES_LEN);
        end
        u0 = und_cnt;
        load_byte(8'h81);
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mslot(17, 31, 47, rd);
            got = {got[6:0], rd};
        end
        total++;
        if (got !== 8'h81 || und_cnt - u0 !== 0) begin
            bad++;
            $display("FAIL abort_next_byte: read %h underruns %0d, required 81 0", got, und_cnt - u0);
        end
    endtask

    task automatic test_async_reset();
        tx_mode = 1'b1;
        load_byte(8'h00);
        master_low = 1'b1;
        repeat (6) tick();
        master_low = 1'b0;
        repeat (4) tick();
        total++;
        if (drive_low !== 1'b1 || bus !== 1'b0) begin
            bad++;
            $display("FAIL hold_drive: drive_low=%b bus=%b, required 1 0", drive_low, bus);
        end
        reset = 1'b1;
        #1;
        total++;
        if (drive_low !== 1'b0 || bus !== 1'b1) begin
            bad++;
            $display("FAIL async_release: drive_low=%b bus=%b, required 0 1", drive_low, bus);
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if (tx_ready !== 1'b1 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL async_values: tx_ready=%b rx_data=%h, required 1 00", tx_ready, rx_data);
        end
    endtask

    initial begin
        reset      = 1'b1;
        tx_mode    = 1'b0;
        tx_data    = 8'h00;
        tx_load    = 1'b0;
        master_low = 1'b0;
        test_reset();
        test_bus_reset();
        test_transmit();
        test_underrun();
        test_receive();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
